iq_averager_mc: RTL and testbench
=================================

Name: iq_averager_mc

Overview:
Multi-channel, parametrised successor to the single-channel MSF IQ averager. It averages NCH signed sample streams (I, Q, and spare channels) over a programmable number of MSF carrier periods. Two modes are supported: block average and per-sample exponential average. Results are scaled by a runtime shift and saturated to the sample width. A rising edge on the one-second marker realigns the windows. The block sits between the IQ demodulator and the phase/bit-decision logic.

Parameters:
NCH, 2, number of channels (ch0 = I, ch1 = Q, others spare)
W, 16, signed sample and average width
ACC_W, 32, signed accumulator width per channel (ACC_W >= W+8)
CW, 13, width of the period count and number_msf_periods
SCNT_W, 16, width of the sample_count output

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
amplitude  in  NCH*W  packed signed samples; channel k is bits [k*W +: W]
load_val  in  1  sample strobe; one-cycle pulse
msf_carrier_pulse  in  1  one-cycle pulse per carrier period
one_sec_marker  in  1  level; the rising edge realigns the window
number_msf_periods  in  CW  window length in carrier periods; 0 is treated as 1
avg_shift  in  5  arithmetic right shift applied to the result (0..ACC_W-W)
mode  in  1  0 = block average, 1 = exponential average
average  out  NCH*W  packed signed results
valid  out  1  one-cycle result strobe
counter  out  CW  carrier periods counted in the current window
sample_count  out  SCNT_W  samples in the last reported window
overflow  out  1  saturation occurred in the last reported window
synced  out  1  set by the first marker edge; cleared only by rst

Behaviour:
- Reset (rst=1 on a clock edge) forces every output to 0 and clears all accumulators, counters, EMA registers and the marker edge register. State goes to IDLE.
- States:
  - IDLE: discard samples. Leave IDLE on the first msf_carrier_pulse or marker rising edge; go to ACCUM with a cleared window.
  - ACCUM: normal operation.
  - CLOSE: single cycle; output registers are updated here.
- Window close: in ACCUM, a msf_carrier_pulse that makes counter+1 >= max(number_msf_periods,1) closes the window.
  - The next state is CLOSE. valid=1 during the CLOSE cycle, i.e. 1 cycle after the closing pulse.
  - Counter returns to 0.
  - A load_val coincident with the closing pulse belongs to the closing window.
  - A load_val during CLOSE belongs to the new window; no sample is ever lost.
- Block mode:
  - acc_k += sign-extended sample on each load_val.
  - At close: average_k = sat_W(acc_k >>> avg_shift), then acc_k is cleared.
  - sample_count = samples in the window, saturating at all-ones.
- EMA mode:
  - On each load_val: ema_k <= ema_k + x_k - (ema_k >>> avg_shift).
  - At close: average_k = sat_W(ema_k >>> avg_shift). ema_k is NOT cleared at close.
  - Steady state is exact: constant x gives ema = x*2^shift.
- Saturation:
  - The accumulator clamps at ACC_W signed min/max instead of wrapping.
  - The output clamps to [-2^(W-1), 2^(W-1)-1].
  - Either clamp sets the internal window-overflow flag; it is copied to overflow at close and then cleared.
- Marker: rising edge detected against the previous-cycle value.
  - Aborts the current window: acc, counter and sample count are cleared, and ema_k is cleared. No valid is produced.
  - Sets synced.
  - If the marker edge coincides with a closing pulse, the marker wins: no valid.
- number_msf_periods, mode and avg_shift are sampled only at window start (leaving IDLE, at CLOSE, or at a marker edge). Mid-window changes take effect in the next window.
- Outputs hold between valid pulses.
- counter is live and increments on every msf_carrier_pulse in ACCUM.

Test Plan:
- Block mode, NCH=2, I=1080, Q=-540; load_val every 4 cycles; carrier every 16 cycles; N=16; shift=6 -> every 256 cycles valid=1 with average I=1080, Q=-540, sample_count=64, overflow=0.
- Same setup, then I steps to 108 mid-stream -> first full window after the step reports 108 exactly; the window containing the step reports the exact weighted value.
- EMA mode, constant I=1000, shift=4, N=1 -> average rises monotonically to exactly 1000 and holds; valid every 16 cycles.
- I=32767 with shift=0, 64 samples -> average=32767 and overflow=1; with shift=6 -> 32767 and overflow=0.
- Marker edge mid-window at counter=7 -> no valid for that window, synced=1, and the next valid comes 16 carrier pulses after the marker. Marker coincident with the closing pulse -> no valid.
- N=0 -> valid after every carrier pulse. rst asserted mid-window -> all outputs 0 the next cycle, block back in IDLE.

Source files
------------

// File: rtl/iq_averager_mc.sv
// Multi-channel IQ averager: block or exponential averaging of NCH signed streams
// over a programmable number of carrier periods, realigned by the one-second marker.
module iq_averager_mc #(
    parameter int NCH    = 2,
    parameter int W      = 16,
    parameter int ACC_W  = 32,
    parameter int CW     = 13,
    parameter int SCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH*W-1:0]    amplitude,
    input  logic                load_val,
    input  logic                msf_carrier_pulse,
    input  logic                one_sec_marker,
    input  logic [CW-1:0]       number_msf_periods,
    input  logic [4:0]          avg_shift,
    input  logic                mode,
    output logic [NCH*W-1:0]    average,
    output logic                valid,
    output logic [CW-1:0]       counter,
    output logic [SCNT_W-1:0]   sample_count,
    output logic                overflow,
    output logic                synced
);
    localparam int XW = ACC_W + 2;
    localparam logic signed [XW-1:0]    ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [XW-1:0]    ACC_MIN = {3'b111, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, CLOSE = 2'd2} state_t;

    function automatic logic acc_hit(input logic signed [XW-1:0] v);
        return (v > ACC_MAX) || (v < ACC_MIN);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] r;
        if (v > ACC_MAX) r = ACC_MAX;
        else if (v < ACC_MIN) r = ACC_MIN;
        else r = v;
        return r[ACC_W-1:0];
    endfunction

    function automatic logic out_hit(input logic signed [ACC_W-1:0] v);
        return (v > OUT_MAX) || (v < OUT_MIN);
    endfunction

    function automatic logic [W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > OUT_MAX) r = OUT_MAX;
        else if (v < OUT_MIN) r = OUT_MIN;
        else r = v;
        return r[W-1:0];
    endfunction

    state_t                  state_r;
    logic signed [ACC_W-1:0] acc_r [NCH];
    logic signed [ACC_W-1:0] ema_r [NCH];
    logic [CW-1:0]           counter_r;
    logic [SCNT_W-1:0]       scnt_r;
    logic                    wovf_r;
    logic                    marker_d_r;
    logic [CW-1:0]           n_r;
    logic [4:0]              shift_r;
    logic                    mode_r;
    logic [NCH*W-1:0]        average_r;
    logic                    valid_r;
    logic [SCNT_W-1:0]       sample_count_r;
    logic                    overflow_r;
    logic                    synced_r;

    logic signed [W-1:0]     samp_s    [NCH];
    logic signed [ACC_W-1:0] ema_dec_s [NCH];
    logic signed [XW-1:0]    acc_sum_s [NCH];
    logic signed [XW-1:0]    ema_sum_s [NCH];
    logic signed [ACC_W-1:0] acc_nxt_s [NCH];
    logic signed [ACC_W-1:0] ema_nxt_s [NCH];
    logic signed [ACC_W-1:0] res_sh_s  [NCH];
    logic [NCH*W-1:0]        avg_nxt_s;
    logic                    acc_clamp_s;
    logic                    out_clamp_s;
    logic [SCNT_W-1:0]       scnt_nxt_s;
    logic [CW-1:0]           n_eff_s;
    logic                    close_s;
    logic                    marker_edge_s;

    assign marker_edge_s = one_sec_marker & ~marker_d_r;
    assign n_eff_s       = (n_r == {CW{1'b0}}) ? CW'(1) : n_r;
    assign close_s       = msf_carrier_pulse &&
                           ((CW+1)'(counter_r) + (CW+1)'(1) >= (CW+1)'(n_eff_s));
    assign scnt_nxt_s    = (load_val && (scnt_r != {SCNT_W{1'b1}})) ? scnt_r + SCNT_W'(1) : scnt_r;

    // Next accumulator/EMA values including the current sample, plus the scaled result
    always_comb begin
        acc_clamp_s = 1'b0;
        out_clamp_s = 1'b0;
        avg_nxt_s   = '0;
        for (int k = 0; k < NCH; k++) begin
            samp_s[k]    = amplitude[k*W +: W];
            ema_dec_s[k] = ema_r[k] >>> shift_r;
            if (load_val && !mode_r) begin
                acc_sum_s[k] = XW'(acc_r[k]) + XW'(samp_s[k]);
            end else begin
                acc_sum_s[k] = XW'(acc_r[k]);
            end
            if (load_val && mode_r) begin
                ema_sum_s[k] = XW'(ema_r[k]) + XW'(samp_s[k]) - XW'(ema_dec_s[k]);
            end else begin
                ema_sum_s[k] = XW'(ema_r[k]);
            end
            acc_nxt_s[k] = sat_acc(acc_sum_s[k]);
            ema_nxt_s[k] = sat_acc(ema_sum_s[k]);
            acc_clamp_s  = acc_clamp_s | acc_hit(acc_sum_s[k]) | acc_hit(ema_sum_s[k]);
            res_sh_s[k]  = (mode_r ? ema_nxt_s[k] : acc_nxt_s[k]) >>> shift_r;
            avg_nxt_s[k*W +: W] = sat_out(res_sh_s[k]);
            out_clamp_s  = out_clamp_s | out_hit(res_sh_s[k]);
        end
    end

    // Window control, accumulation and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            counter_r      <= '0;
            scnt_r         <= '0;
            wovf_r         <= 1'b0;
            marker_d_r     <= 1'b0;
            n_r            <= '0;
            shift_r        <= '0;
            mode_r         <= 1'b0;
            average_r      <= '0;
            valid_r        <= 1'b0;
            sample_count_r <= '0;
            overflow_r     <= 1'b0;
            synced_r       <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                acc_r[k] <= '0;
                ema_r[k] <= '0;
            end
        end else begin
            marker_d_r <= one_sec_marker;
            valid_r    <= 1'b0;
            if (marker_edge_s || (state_r == IDLE && msf_carrier_pulse)) begin
                // The marker aborts the window and restarts the EMA from zero
                state_r   <= ACCUM;
                counter_r <= '0;
                scnt_r    <= '0;
                wovf_r    <= 1'b0;
                n_r       <= number_msf_periods;
                shift_r   <= avg_shift;
                mode_r    <= mode;
                synced_r  <= synced_r | marker_edge_s;
                for (int k = 0; k < NCH; k++) begin
                    acc_r[k] <= '0;
                    ema_r[k] <= '0;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    ACCUM, CLOSE: begin
                        for (int k = 0; k < NCH; k++) begin
                            ema_r[k] <= ema_nxt_s[k];
                        end
                        if (state_r == ACCUM && close_s) begin
                            state_r        <= CLOSE;
                            valid_r        <= 1'b1;
                            average_r      <= avg_nxt_s;
                            sample_count_r <= scnt_nxt_s;
                            overflow_r     <= wovf_r | acc_clamp_s | out_clamp_s;
                            counter_r      <= '0;
                            scnt_r         <= '0;
                            wovf_r         <= 1'b0;
                            n_r            <= number_msf_periods;
                            shift_r        <= avg_shift;
                            mode_r         <= mode;
                            for (int k = 0; k < NCH; k++) begin
                                acc_r[k] <= '0;
                            end
                        end else begin
                            state_r <= ACCUM;
                            scnt_r  <= scnt_nxt_s;
                            wovf_r  <= wovf_r | acc_clamp_s;
                            for (int k = 0; k < NCH; k++) begin
                                acc_r[k] <= acc_nxt_s[k];
                            end
                            if (state_r == ACCUM && msf_carrier_pulse) begin
                                counter_r <= counter_r + CW'(1);
                            end else begin
                                counter_r <= counter_r;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign average      = average_r;
    assign valid        = valid_r;
    assign counter      = counter_r;
    assign sample_count = sample_count_r;
    assign overflow     = overflow_r;
    assign synced       = synced_r;
endmodule

// File: tb/tb_iq_averager_mc.sv
// Directed bench for iq_averager_mc: block, step, saturation, marker, EMA, N=0 and reset.
module tb_iq_averager_mc;
    localparam int NCH = 2, W = 16, ACC_W = 32, CW = 13, SCNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NCH*W-1:0]    amplitude;
    logic                load_val, msf_carrier_pulse, one_sec_marker, mode;
    logic [CW-1:0]       number_msf_periods;
    logic [4:0]          avg_shift;
    logic [NCH*W-1:0]    average;
    logic                valid, overflow, synced;
    logic [CW-1:0]       counter;
    logic [SCNT_W-1:0]   sample_count;

    logic signed [W-1:0] in_i, in_q, avg_i, avg_q;
    assign amplitude = {in_q, in_i};
    assign avg_i = average[W-1:0];
    assign avg_q = average[2*W-1:W];

    int errors = 0, checks = 0, ph = 0, ema_m = 0;
    bit ema_on = 1'b0;

    iq_averager_mc #(.NCH(NCH), .W(W), .ACC_W(ACC_W), .CW(CW), .SCNT_W(SCNT_W)) dut (
        .clk(clk), .rst(rst), .amplitude(amplitude), .load_val(load_val),
        .msf_carrier_pulse(msf_carrier_pulse), .one_sec_marker(one_sec_marker),
        .number_msf_periods(number_msf_periods), .avg_shift(avg_shift), .mode(mode),
        .average(average), .valid(valid), .counter(counter), .sample_count(sample_count),
        .overflow(overflow), .synced(synced)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: load every 4th cycle, carrier every 16th, reference EMA tracks loads
    task automatic tick();
        load_val = (ph % 4 == 0);
        msf_carrier_pulse = (ph % 16 == 15);
        if (ema_on && load_val) ema_m = ema_m + int'(in_i) - (ema_m >>> 4);
        @(posedge clk); #1;
        ph++;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid && n < max);
    endtask

    task automatic check_window(input string tag, input int exp_n, input int ei, input int eq,
                                input int ecnt, input int eovf);
        int n;
        wait_valid(exp_n + 40, n);
        chk({tag, ".valid"}, valid, 1);
        chk({tag, ".ticks"}, n, exp_n);
        chk({tag, ".i"}, avg_i, ei);
        chk({tag, ".q"}, avg_q, eq);
        chk({tag, ".cnt"}, sample_count, ecnt);
        chk({tag, ".ovf"}, overflow, eovf);
        chk({tag, ".counter"}, counter, 0);
    endtask

    initial begin
        int n;
        logic signed [W-1:0] prev;
        rst = 1'b1; load_val = 1'b1; msf_carrier_pulse = 1'b1; one_sec_marker = 1'b0;
        in_i = 16'sd1080; in_q = -16'sd540; mode = 1'b0;
        number_msf_periods = 13'd16; avg_shift = 5'd6;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.avg", average, 0);
        chk("rst.valid", valid, 0);
        chk("rst.counter", counter, 0);
        chk("rst.synced", synced, 0);
        rst = 1'b0;

        // Block mode, constant inputs
        check_window("blk1", 272, 1080, -540, 64, 0);
        check_window("blk2", 256, 1080, -540, 64, 0);

        // Step on I halfway through a window: (32*1080 + 32*108)/64 = 594
        repeat (128) tick();
        in_i = 16'sd108;
        check_window("step", 128, 594, -540, 64, 0);
        check_window("post_step", 256, 108, -540, 64, 0);

        // Full-scale input; the shift change only applies from the next window
        in_i = 16'sd32767; avg_shift = 5'd0;
        check_window("fs_sh6", 256, 32767, -540, 64, 0);
        check_window("fs_sh0", 256, 32767, -32768, 64, 1);
        in_i = 16'sd1080; avg_shift = 5'd6;
        check_window("sat_neg", 256, 32767, -32768, 64, 1);
        check_window("recover", 256, 1080, -540, 64, 0);

        // Marker edge mid-window at counter=7
        n = 0;
        while (counter != 13'd7 && n < 300) begin
            tick();
            n++;
        end
        chk("mk.counter7", counter, 7);
        one_sec_marker = 1'b1;
        tick();
        chk("mk.valid", valid, 0);
        chk("mk.counter", counter, 0);
        chk("mk.synced", synced, 1);
        chk("mk.hold_i", avg_i, 1080);
        chk("mk.hold_cnt", sample_count, 64);
        // 63 samples: 68040>>>6 = 1063, -34020>>>6 = -532
        check_window("mk.next", 255, 1063, -532, 63, 0);

        // Marker coincident with the closing pulse
        one_sec_marker = 1'b0;
        while (ph % 256 != 127) tick();
        chk("mkc.counter15", counter, 15);
        one_sec_marker = 1'b1;
        tick();
        chk("mkc.valid", valid, 0);
        chk("mkc.counter", counter, 0);
        one_sec_marker = 1'b0;
        check_window("mkc.next", 256, 1080, -540, 64, 0);

        // EMA, shift 4, N=1; the transition window is still a block window
        mode = 1'b1; avg_shift = 5'd4; number_msf_periods = 13'd1; in_i = 16'sd1000; in_q = 16'sd0;
        check_window("ema.trans", 256, 1000, 0, 64, 0);
        ema_on = 1'b1; ema_m = 0; prev = '0;
        for (int w = 0; w < 45; w++) begin
            wait_valid(40, n);
            chk("ema.ticks", n, 16);
            chk("ema.i", avg_i, ema_m >>> 4);
            chk("ema.mono", (avg_i >= prev), 1);
            prev = avg_i;
        end
        chk("ema.final", avg_i, 1000);
        chk("ema.q", avg_q, 0);
        chk("ema.ovf", overflow, 0);

        // N=0 behaves as one period; 4 samples, shift 2
        ema_on = 1'b0; mode = 1'b0; number_msf_periods = 13'd0; avg_shift = 5'd2;
        in_i = 16'sd500; in_q = -16'sd7;
        wait_valid(40, n);
        for (int w = 0; w < 3; w++) check_window("n0", 16, 500, -7, 4, 0);

        // Reset mid-window, then the block must restart from IDLE
        number_msf_periods = 13'd16;
        wait_valid(40, n);
        repeat (40) tick();
        chk("pre_rst.counter", counter, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        number_msf_periods = 13'd0;
        chk("mrst.avg", average, 0);
        chk("mrst.valid", valid, 0);
        chk("mrst.counter", counter, 0);
        chk("mrst.cnt", sample_count, 0);
        chk("mrst.ovf", overflow, 0);
        chk("mrst.synced", synced, 0);
        while (ph % 16 != 0) tick();
        chk("idle_exit.valid", valid, 0);
        chk("idle_exit.counter", counter, 0);
        check_window("post_rst", 16, 500, -7, 4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
